// File: rtl/parity_frame_rx.sv
// Serial deframer for start/d0..d3/parity/stop frames, sampled on an external bit strobe.
// Reports the nibble, parity mismatch and framing errors, and keeps a saturating error count.
module parity_frame_rx #(
  parameter bit PARITY_ODD = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             din,
  input  logic             cnt_clr,
  output logic [3:0]       data,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t     state;
  logic [3:0] shift_reg;
  logic [1:0] bit_idx;
  logic       par_rx;

  // Frame state machine; every transition waits for a bit strobe, pulses last one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      par_rx     <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!din) begin
              state   <= DATA;
              bit_idx <= 2'd0;
            end
          end
          DATA: begin
            shift_reg[bit_idx] <= din;
            if (bit_idx == 2'd3) state <= PAR;
            else bit_idx <= bit_idx + 2'd1;
          end
          PAR: begin
            par_rx <= din;
            state  <= STOP;
          end
          STOP: begin
            // A bad stop bit leaves data/parity_err from the last good frame untouched.
            if (din) begin
              data       <= shift_reg;
              parity_err <= ((^shift_reg) ^ par_rx) != PARITY_ODD;
              valid      <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Counts the registered error pulses one clock later, so a clear in the pulse cycle wins.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      err_cnt <= '0;
    end else if (((valid && parity_err) || frame_err) && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: three instances (even/8-bit, odd/8-bit, even/2-bit counter) on one line,
// checked every cycle against a frame-level event model plus table and hand-written sequences.
module tb_parity_frame_rx;

  logic clk, rst, bit_en, din, cnt_clr;
  logic [3:0] data0, data1, data2;
  logic valid0, valid1, valid2, perr0, perr1, perr2, ferr0, ferr1, ferr2, busy0, busy1, busy2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  parity_frame_rx #(.PARITY_ODD(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .bit_en(bit_en), .din(din), .cnt_clr(cnt_clr),
    .data(data0), .valid(valid0), .parity_err(perr0), .frame_err(ferr0),
    .err_cnt(cnt0), .busy(busy0));
  parity_frame_rx #(.PARITY_ODD(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bit_en(bit_en), .din(din), .cnt_clr(cnt_clr),
    .data(data1), .valid(valid1), .parity_err(perr1), .frame_err(ferr1),
    .err_cnt(cnt1), .busy(busy1));
  parity_frame_rx #(.PARITY_ODD(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bit_en(bit_en), .din(din), .cnt_clr(cnt_clr),
    .data(data2), .valid(valid2), .parity_err(perr2), .frame_err(ferr2),
    .err_cnt(cnt2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       good;
    logic [3:0] d;
    logic       par;
  } ev_t;

  typedef struct {
    logic [3:0] d;
    logic       par;
    logic       stop;
    int         gap;
    logic       expValid;
    logic       expFerr;
    logic       expPerr;
    logic [3:0] expData;
  } vec_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic       expV = 1'b0;
  logic       expF = 1'b0;
  logic [3:0] expData = 4'h0;
  logic [2:0] expPe = 3'b000;
  int         expCnt[3] = '{0, 0, 0};
  int         maxCnt[3] = '{255, 255, 3};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Frame-level model: a stop bit queued by the driver becomes a pulse on the following cycle.
  task automatic modelStep();
    ev_t ev;
    logic p;
    cyc++;
    if (rst) begin
      expV = 1'b0; expF = 1'b0; expData = 4'h0; expPe = 3'b000;
      for (int j = 0; j < 3; j++) expCnt[j] = 0;
      evq.delete();
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (cnt_clr) expCnt[j] = 0;
        else if (((expV && expPe[j]) || expF) && expCnt[j] < maxCnt[j]) expCnt[j]++;
      end
      expV = 1'b0;
      expF = 1'b0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev = evq.pop_front();
        if (ev.good) begin
          p       = (^ev.d) ^ ev.par;
          expV    = 1'b1;
          expData = ev.d;
          expPe   = {p, ~p, p};
          expPe   = {p, ~p, p};
        end else begin
          expF = 1'b1;
        end
      end
    end
  endtask

  task automatic checkAll();
    logic [3:0] d;
    logic v, pe, fe;
    logic [31:0] c;
    for (int j = 0; j < 3; j++) begin
      case (j)
        0: begin d = data0; v = valid0; pe = perr0; fe = ferr0; c = 32'(cnt0); end
        1: begin d = data1; v = valid1; pe = perr1; fe = ferr1; c = 32'(cnt1); end
        default: begin d = data2; v = valid2; pe = perr2; fe = ferr2; c = 32'(cnt2); end
      endcase
      checkOutput($sformatf("dut%0d.valid", j), 32'(v), 32'(expV));
      checkOutput($sformatf("dut%0d.frame_err", j), 32'(fe), 32'(expF));
      checkOutput($sformatf("dut%0d.data", j), 32'(d), 32'(expData));
      checkOutput($sformatf("dut%0d.parity_err", j), 32'(pe), 32'(expPe[j]));
      checkOutput($sformatf("dut%0d.err_cnt", j), c, 32'(expCnt[j]));
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    checkAll();
  end

  // Sends one frame; gap idle clocks precede every bit, gap=0 keeps bit_en high throughout.
  task automatic applyStimulus(input logic [3:0] d, input logic par, input logic stop, input int gap);
    logic [6:0] line;
    line = {stop, par, d, 1'b0};
    for (int i = 0; i < 7; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bit_en = 1'b0;
        din    = 1'($urandom);
      end
      @(negedge clk);
      din    = line[i];
      bit_en = 1'b1;
      if (i == 6) evq.push_back('{cyc + 1, stop, d, par});
    end
  endtask

  task automatic endFrame();
    @(negedge clk);
    bit_en = 1'b0;
    din    = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'hD, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 4'hD};
    vecs[1] = '{4'hD, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1, 4'hD};
    vecs[2] = '{4'h5, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 4'hD};
    vecs[3] = '{4'h3, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 4'h3};
    vecs[4] = '{4'hA, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b1, 4'hA};
    vecs[5] = '{4'hF, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 4'hF};

    rst = 1'b1; bit_en = 1'b0; din = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", 32'(busy0), 32'd0);
    checkOutput("reset.cnt", 32'(cnt0), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k].d, vecs[k].par, vecs[k].stop, vecs[k].gap);
      endFrame();
      checkOutput($sformatf("vec%0d.valid", k), 32'(valid0), 32'(vecs[k].expValid));
      checkOutput($sformatf("vec%0d.frame_err", k), 32'(ferr0), 32'(vecs[k].expFerr));
      checkOutput($sformatf("vec%0d.parity_err", k), 32'(perr0), 32'(vecs[k].expPerr));
      checkOutput($sformatf("vec%0d.data", k), 32'(data0), 32'(vecs[k].expData));
      checkOutput($sformatf("vec%0d.busy", k), 32'(busy0), 32'd0);
      repeat (2) @(negedge clk);
    end
    checkOutput("table.cnt_even", 32'(cnt0), 32'd3);
    checkOutput("table.cnt_odd", 32'(cnt1), 32'd4);
    checkOutput("table.cnt_w2", 32'(cnt2), 32'd3);

    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(4'hD, 1'b0, 1'b1, 1);
      endFrame();
      @(negedge clk);
      checkOutput($sformatf("sat%0d.cnt_w2", k), 32'(cnt2), (k >= 3) ? 32'd3 : 32'(k));
      checkOutput($sformatf("sat%0d.cnt_odd", k), 32'(cnt1), 32'd0);
    end
    applyStimulus(4'hD, 1'b0, 1'b1, 1);
    endFrame();
    cnt_clr = 1'b1;
    checkOutput("clr.valid", 32'(valid2), 32'd1);
    @(negedge clk);
    cnt_clr = 1'b0;
    checkOutput("clr.cnt_w2", 32'(cnt2), 32'd0);
    checkOutput("clr.cnt_even", 32'(cnt0), 32'd0);

    applyStimulus(4'h3, 1'b0, 1'b1, 0);
    checkOutput("b2b.busy_mid", 32'(busy0), 32'd1);
    applyStimulus(4'hC, 1'b0, 1'b1, 0);
    endFrame();
    checkOutput("b2b.valid", 32'(valid0), 32'd1);
    checkOutput("b2b.data", 32'(data0), 32'hC);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      repeat (3) begin @(negedge clk); bit_en = 1'b0; end
      @(negedge clk);
      din    = (i == 0) ? 1'b0 : (i == 1);
      bit_en = 1'b1;
    end
    @(negedge clk);
    bit_en = 1'b0;
    checkOutput("rstmid.busy_before", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstmid.busy_after", 32'(busy0), 32'd0);
    applyStimulus(4'hA, 1'b0, 1'b1, 3);
    endFrame();
    checkOutput("rstmid.valid", 32'(valid0), 32'd1);
    checkOutput("rstmid.data", 32'(data0), 32'hA);
    checkOutput("rstmid.cnt", 32'(cnt0), 32'd0);
    repeat (2) @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); din = 1'b1; bit_en = 1'b1;
        @(negedge clk); bit_en = 1'b0;
      end
      applyStimulus(4'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(0, 3));
      endFrame();
      cnt_clr = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      cnt_clr = 1'b0;
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
